// File: rtl/spi_seq_pkg.sv
// Shared types and register map for the SPI-slave register-port sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    INIT_CTRL = 3'd0,
    INIT_STAT = 3'd1,
    IDLE      = 3'd2,
    RD_DATA   = 3'd3,
    RD_STAT   = 3'd4,
    CLR_STAT  = 3'd5,
    WR_DATA   = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_A0   = 2'd1,
    PH_A1   = 2'd2,
    PH_GAP  = 2'd3
  } acc_phase_e;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;

  localparam int ROE_BIT = 3;
  localparam int TOE_BIT = 4;

endpackage

// File: rtl/spi_reg_access.sv
// Three-cycle register access on the SPI slave port: A0, A1 with strobes held, then a
// strobe-free GAP. A new access may be launched during GAP so chained accesses stay 3 cycles.
module spi_reg_access
  import spi_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [2:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] data_to_cpu_i,
  output logic              spi_select_o,
  output logic [2:0]        mem_addr_o,
  output logic              read_n_o,
  output logic              write_n_o,
  output logic [DATA_W-1:0] data_from_cpu_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rdata_o
);

  acc_phase_e        phase_q, phase_d;
  logic              sel_q, sel_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [2:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_IDLE;
      sel_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      sel_q   <= sel_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    sel_d   = sel_q;
    rd_n_d  = rd_n_q;
    wr_n_d  = wr_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (phase_q)
      PH_IDLE, PH_GAP: begin
        phase_d = PH_IDLE;
        sel_d   = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        if (start_i) begin
          phase_d = PH_A0;
          sel_d   = 1'b1;
          rd_n_d  = wr_i;
          wr_n_d  = !wr_i;
          addr_d  = addr_i;
          if (wr_i) wdata_d = wdata_i;
        end
      end
      PH_A0:   phase_d = PH_A1;
      PH_A1: begin
        phase_d = PH_GAP;
        sel_d   = 1'b0;
        rd_n_d  = 1'b1;
        wr_n_d  = 1'b1;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign spi_select_o    = sel_q;
  assign mem_addr_o      = addr_q;
  assign read_n_o        = rd_n_q;
  assign write_n_o       = wr_n_q;
  assign data_from_cpu_o = wdata_q;
  assign busy_o          = (phase_q == PH_A0) || (phase_q == PH_A1);
  assign done_o          = (phase_q == PH_GAP);
  // Read data is taken straight off the bus at the end of A1.
  assign rd_valid_o      = (phase_q == PH_A1) && !rd_n_q;
  assign rdata_o         = data_to_cpu_i;

endmodule

// File: rtl/spi_slave_sequencer.sv
// Hardware master for the SPI-slave register port: init, TX/RX stream transfer,
// status polling after each RX word with overrun counting and clearing.
module spi_slave_sequencer
  import spi_seq_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 8,
  parameter bit                IDLE_FILL = 1'b0,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              spi_select,
  output logic [2:0]        mem_addr,
  output logic              read_n,
  output logic              write_n,
  output logic [DATA_W-1:0] data_from_cpu,
  input  logic [DATA_W-1:0] data_to_cpu,
  input  logic              dataavailable,
  input  logic              readyfordata,
  output logic [CNT_W-1:0]  ovr_cnt,
  output logic              err_pulse
);

  seq_state_e        state_q, state_d;
  logic              acc_start, acc_wr;
  logic [2:0]        acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_busy, acc_done, acc_rd_valid;
  logic [DATA_W-1:0] acc_rdata;
  logic              tx_take;

  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [CNT_W-1:0]  ovr_cnt_q;
  logic              err_pulse_q, err_pulse_d;

  spi_reg_access #(.DATA_W(DATA_W)) u_acc (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (acc_start),
    .wr_i           (acc_wr),
    .addr_i         (acc_addr),
    .wdata_i        (acc_wdata),
    .data_to_cpu_i  (data_to_cpu),
    .spi_select_o   (spi_select),
    .mem_addr_o     (mem_addr),
    .read_n_o       (read_n),
    .write_n_o      (write_n),
    .data_from_cpu_o(data_from_cpu),
    .busy_o         (acc_busy),
    .done_o         (acc_done),
    .rd_valid_o     (acc_rd_valid),
    .rdata_o        (acc_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= INIT_CTRL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_CTRL: if (acc_done) state_d = INIT_STAT;
      INIT_STAT: if (acc_done) state_d = IDLE;
      IDLE: begin
        // rx_valid_q is the pre-handshake value, so a same-cycle pop delays the next read.
        if (dataavailable && !rx_valid_q)      state_d = RD_DATA;
        else if (readyfordata && tx_valid)     state_d = WR_DATA;
        else if (IDLE_FILL && readyfordata)    state_d = WR_DATA;
      end
      RD_DATA:   if (acc_done) state_d = RD_STAT;
      RD_STAT:   if (acc_done) state_d = err_pulse_q ? CLR_STAT : IDLE;
      CLR_STAT:  if (acc_done) state_d = IDLE;
      WR_DATA:   if (acc_done) state_d = IDLE;
      default:   state_d = INIT_CTRL;
    endcase
  end

  // An access launches on entry to an access state, or in the very first
  // INIT_CTRL cycle after reset when nothing is in flight yet.
  always_comb begin
    tx_take   = (state_q == IDLE) && (state_d == WR_DATA) && tx_valid && readyfordata;
    tx_ready  = tx_take;
    acc_start = (state_d != IDLE) && !acc_busy && ((state_d != state_q) || !acc_done);
    acc_wr    = 1'b1;
    acc_addr  = ADDR_CONTROL;
    acc_wdata = '0;
    case (state_d)
      INIT_STAT, CLR_STAT: acc_addr = ADDR_STATUS;
      RD_DATA: begin
        acc_wr   = 1'b0;
        acc_addr = ADDR_RXDATA;
      end
      RD_STAT: begin
        acc_wr   = 1'b0;
        acc_addr = ADDR_STATUS;
      end
      WR_DATA: begin
        acc_addr  = ADDR_TXDATA;
        acc_wdata = tx_take ? tx_data : IDLE_WORD;
      end
      default: acc_addr = ADDR_CONTROL;
    endcase
  end

  assign err_pulse_d = (state_q == RD_STAT) && acc_rd_valid &&
                       (acc_rdata[ROE_BIT] || acc_rdata[TOE_BIT]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      ovr_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= err_pulse_d;
      if (err_pulse_d && (ovr_cnt_q != {CNT_W{1'b1}})) ovr_cnt_q <= ovr_cnt_q + 1'b1;
      if ((state_q == RD_DATA) && acc_rd_valid) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= acc_rdata;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign ovr_cnt   = ovr_cnt_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Directed bench for spi_slave_sequencer with a register-mapped slave model on data_to_cpu.
module tb_spi_slave_sequencer;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              spi_select;
  logic [2:0]        mem_addr;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] data_from_cpu;
  logic [DATA_W-1:0] data_to_cpu;
  logic              dataavailable;
  logic              readyfordata;
  logic [CNT_W-1:0]  ovr_cnt;
  logic              err_pulse;

  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] status_word;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign data_to_cpu = (mem_addr == 3'd0) ? rx_word :
                       (mem_addr == 3'd2) ? status_word : '0;

  spi_slave_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .IDLE_FILL(1'b1), .IDLE_WORD(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .dataavailable(dataavailable), .readyfordata(readyfordata),
    .ovr_cnt(ovr_cnt), .err_pulse(err_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expects the next three cycles to be A0, A1, GAP of the given access.
  task automatic chk_access(input string tag, input bit wr, input logic [2:0] addr,
                            input logic [31:0] wd);
    @(negedge clk);
    chk({tag, "_a0"}, {spi_select, read_n, write_n, mem_addr}, {1'b1, wr, !wr, addr});
    if (wr) chk({tag, "_a0d"}, data_from_cpu, wd);
    chk({tag, "_a0txr"}, tx_ready, 0);
    @(negedge clk);
    chk({tag, "_a1"}, {spi_select, read_n, write_n, mem_addr}, {1'b1, wr, !wr, addr});
    if (wr) chk({tag, "_a1d"}, data_from_cpu, wd);
    @(negedge clk);
    chk({tag, "_gap"}, {spi_select, read_n, write_n}, 3'b011);
  endtask

  initial begin
    int np;
    reset_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    dataavailable = 1'b0; readyfordata = 1'b0; rx_word = '0; status_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {spi_select, read_n, write_n, mem_addr}, 6'b0_1_1_000);
    chk("rst_wdata", data_from_cpu, 0);
    chk("rst_stream", {tx_ready, rx_valid, err_pulse}, 3'b000);
    chk("rst_rxdata", rx_data, 0);
    chk("rst_ovr", ovr_cnt, 0);

    reset_n = 1'b1;
    chk_access("init_ctrl", 1'b1, 3'd3, 32'h0);
    chk_access("init_stat", 1'b1, 3'd2, 32'h0);
    @(negedge clk);
    chk("idle_bus", {spi_select, read_n, write_n}, 3'b011);

    // TX word accepted in IDLE
    tx_valid = 1'b1; tx_data = 32'hA5A5_0001; readyfordata = 1'b1;
    #1 chk("tx_ready", tx_ready, 1);
    chk_access("tx_wr", 1'b1, 3'd1, 32'hA5A5_0001);
    tx_valid = 1'b0; readyfordata = 1'b0;
    @(negedge clk);
    chk("tx_idle", {spi_select, tx_ready}, 2'b00);

    // RX word, clean status
    dataavailable = 1'b1; rx_word = 32'h1234_5678; status_word = 32'h040;
    chk_access("rx_rd", 1'b0, 3'd0, 32'h0);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, 32'h1234_5678);
    chk_access("rx_stat", 1'b0, 3'd2, 32'h0);
    chk("rx_noerr", err_pulse, 0);
    @(negedge clk);
    chk("rx_noclr", spi_select, 0);

    // Backpressure: no new read while rx_valid is held
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold", {spi_select, rx_valid}, 2'b01);
    end
    rx_ready = 1'b1; rx_word = 32'hCAFE_0002;
    @(negedge clk);
    chk("bp_pop_delay", {spi_select, rx_valid}, 2'b00);
    rx_ready = 1'b0; status_word = 32'h008;
    chk_access("roe_rd", 1'b0, 3'd0, 32'h0);
    chk("roe_rxdata", rx_data, 32'hCAFE_0002);
    chk_access("roe_stat", 1'b0, 3'd2, 32'h0);
    chk("roe_err", err_pulse, 1);
    chk("roe_cnt", ovr_cnt, 1);
    chk_access("roe_clr", 1'b1, 3'd2, 32'h0);
    chk("roe_err_1cyc", err_pulse, 0);
    dataavailable = 1'b0; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;

    // Saturation: 300 more overrun status reads
    dataavailable = 1'b1; rx_ready = 1'b1; status_word = 32'h008;
    np = 0;
    for (int c = 0; c < 4000 && np < 300; c++) begin
      @(negedge clk);
      if (err_pulse) begin
        np++;
        if (np == 100) chk("sat_cnt100", ovr_cnt, 101);
        if (np == 254) chk("sat_cnt254", ovr_cnt, 255);
      end
    end
    chk("sat_pulses", np, 300);
    dataavailable = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_cnt", ovr_cnt, 255);
    chk("sat_idle", {spi_select, rx_valid}, 2'b00);
    rx_ready = 1'b0;

    // RX wins over TX in the same IDLE cycle
    dataavailable = 1'b1; readyfordata = 1'b1; tx_valid = 1'b1;
    tx_data = 32'h1111_2222; rx_word = 32'h5555_AAAA; status_word = '0;
    #1 chk("prio_txr0", tx_ready, 0);
    chk_access("prio_rd", 1'b0, 3'd0, 32'h0);
    dataavailable = 1'b0;
    chk("prio_rxdata", rx_data, 32'h5555_AAAA);
    chk_access("prio_stat", 1'b0, 3'd2, 32'h0);
    @(negedge clk);
    chk("prio_txr1", tx_ready, 1);
    chk_access("prio_wr", 1'b1, 3'd1, 32'h1111_2222);
    tx_valid = 1'b0;

    // Idle fill, then reset during A1
    @(negedge clk);
    chk("fill_txr", tx_ready, 0);
    @(negedge clk);
    chk("fill_a0", {spi_select, write_n, mem_addr}, {2'b10, 3'd1});
    chk("fill_data", data_from_cpu, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("fill_a1", write_n, 0);
    reset_n = 1'b0; readyfordata = 1'b0;
    #1 chk("mid_rst_bus", {spi_select, read_n, write_n}, 3'b011);
    chk("mid_rst_state", {rx_valid, ovr_cnt}, 9'h0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_access("reinit_ctrl", 1'b1, 3'd3, 32'h0);
    chk_access("reinit_stat", 1'b1, 3'd2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
